csr_regfile: RTL and testbench
==============================

CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 Parameter: CPU_ID, default 32'h0, reset value of TID.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 csr_we  in  1  CSR write strobe from writeback.
REQ-005 csr_num  in  14  CSR address for read and write.
REQ-006 csr_wmask  in  32  per-bit write enable.
REQ-007 csr_wdata  in  32  write data.
REQ-008 csr_rdata  out  32  read data for csr_num.
REQ-009 excp_flush  in  1  exception commit pulse.
REQ-010 ertn_flush  in  1  ertn commit pulse.
REQ-011 ecode  in  6  exception code.
REQ-012 esubcode  in  3  exception subcode.
REQ-013 epc  in  32  PC of the faulting instruction.
REQ-014 hw_int_in  in  8  level hardware interrupt lines.
REQ-015 era  out  32  ERA register, redirect target for ertn.
REQ-016 eentry  out  32  EENTRY register, redirect target for exceptions.
REQ-017 has_int  out  1  interrupt pending and enabled.

Function
REQ-018 Implemented CSRs: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-019 csr_rdata is combinational from csr_num, with zero latency; unimplemented numbers read 0.
REQ-020 A write updates the register at the next edge as (old & ~wmask) | (wdata & wmask), applied only to writable fields.
REQ-021 Writes to unimplemented numbers, read-only fields, or TVAL are ignored.
REQ-022 Writable fields: CRMD PLV[1:0], IE[2], DA[3], PG[4]; PRMD PPLV[1:0], PIE[2]; ECFG LIE[12:0] excluding bit 10; ESTAT IS[1:0]; ERA all; EENTRY [31:6]; SAVE0-3 all; TID all; TCFG all.
REQ-023 On excp_flush, the block SHALL apply these updates in one cycle: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ESTAT.Ecode[21:16]<=ecode, ESTAT.EsubCode[30:22]<={6'b0,esubcode}, ERA<=epc.
REQ-024 On ertn_flush without excp_flush: CRMD.PLV<=PRMD.PPLV and CRMD.IE<=PRMD.PIE.
REQ-025 excp_flush has priority over ertn_flush; when either flush is high, csr_we is ignored that cycle.
REQ-026 ESTAT.IS[9:2] SHALL equal hw_int_in registered every cycle; IS[10] reads 0.
REQ-027 A TCFG write SHALL load TVAL with {written InitVal[31:2], 2'b00} at the same edge.
REQ-028 When TCFG.En=1, TVAL!=0 and no TCFG write occurs, TVAL decrements by 1 per cycle.
REQ-029 On a cycle with En=1 and TVAL==1: IS[11] is set; TVAL becomes {InitVal,2'b00} if Periodic (TCFG[1]) is 1, else 0 and holds.
REQ-030 With En=0, TVAL holds its value.
REQ-031 Writing TICLR with bit0=1 clears IS[11]; a same-cycle timer set wins. TICLR reads 0.
REQ-032 has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational.
REQ-033 era and eentry SHALL equal the register contents; a same-edge update becomes visible the following cycle.

Reset
REQ-034 While resetn=0: CRMD=32'h8 (DA=1), TID=CPU_ID, all other CSRs=0, and IS[9:2]=0.
REQ-035 Consequent output values during reset: era=0, eentry=0, has_int=0, TVAL=0, timer stopped.
REQ-036 Reset asserted mid-countdown or mid-flush SHALL discard the operation with no partial update.

Structure
REQ-037 CSR numbers, field bit positions and ECODE values SHALL reside in the shared CPU header.
REQ-038 Sub-module csr_timer SHALL hold TCFG, TVAL and the expiry logic, and output a one-cycle timer_set pulse.

Verification
REQ-039 Reset, then read CRMD -> 32'h8; read EENTRY -> 0; has_int=0.
REQ-040 Write EENTRY with wdata FFFF_FFFF and wmask FFFF_FFFF -> reads 32'hFFFF_FFC0; eentry matches on the next cycle.
REQ-041 CRMD.PLV=3, IE=1; excp_flush with ecode 0xB and epc 0x1C00_0100 -> PRMD=0x7, CRMD.PLV=0, CRMD.IE=0, ESTAT[21:16]=0xB, era=0x1C00_0100; a same-cycle csr_we to SAVE0 is dropped.
REQ-042 Then ertn_flush -> CRMD.PLV=3, CRMD.IE=1.
REQ-043 TCFG=0x0000_000B (InitVal=2, periodic, En) -> TVAL 8,7,…,1, then reloads 8 with IS[11]=1; with LIE[11]=1 and IE=1, has_int=1; TICLR write of 1 -> IS[11]=0 next cycle.
REQ-044 hw_int_in=8'h01 with LIE[2]=1 and IE=1 -> ESTAT.IS[2]=1 after one cycle, then has_int=1.

Source files
------------

// File: rtl/csr_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_regfile_pkg
// Description : CSR numbers, field positions, write masks and ECODE values
// Revision    : 1.0 - initial release
// ============================================================================
package csr_regfile_pkg;

  localparam int C_CSR_NUM_W = 14;

  localparam logic [13:0] C_CSR_CRMD   = 14'h0000;
  localparam logic [13:0] C_CSR_PRMD   = 14'h0001;
  localparam logic [13:0] C_CSR_ECFG   = 14'h0004;
  localparam logic [13:0] C_CSR_ESTAT  = 14'h0005;
  localparam logic [13:0] C_CSR_ERA    = 14'h0006;
  localparam logic [13:0] C_CSR_EENTRY = 14'h000C;
  localparam logic [13:0] C_CSR_SAVE0  = 14'h0030;
  localparam logic [13:0] C_CSR_SAVE1  = 14'h0031;
  localparam logic [13:0] C_CSR_SAVE2  = 14'h0032;
  localparam logic [13:0] C_CSR_SAVE3  = 14'h0033;
  localparam logic [13:0] C_CSR_TID    = 14'h0040;
  localparam logic [13:0] C_CSR_TCFG   = 14'h0041;
  localparam logic [13:0] C_CSR_TVAL   = 14'h0042;
  localparam logic [13:0] C_CSR_TICLR  = 14'h0044;

  // Field bit positions
  localparam int C_CRMD_IE       = 2;
  localparam int C_CRMD_DA       = 3;
  localparam int C_TCFG_EN       = 0;
  localparam int C_TCFG_PERIODIC = 1;
  localparam int C_TICLR_CLR     = 0;
  localparam int C_IS_TIMER      = 11;

  // Writable-field masks
  localparam logic [31:0] C_CRMD_WMASK   = 32'h0000_001F;
  localparam logic [31:0] C_PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] C_ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] C_EENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] C_CRMD_RESET   = 32'h0000_0008;

  localparam logic [5:0] C_ECODE_INT = 6'h00;
  localparam logic [5:0] C_ECODE_PIL = 6'h01;
  localparam logic [5:0] C_ECODE_ADE = 6'h08;
  localparam logic [5:0] C_ECODE_ALE = 6'h09;
  localparam logic [5:0] C_ECODE_SYS = 6'h0B;
  localparam logic [5:0] C_ECODE_BRK = 6'h0C;
  localparam logic [5:0] C_ECODE_INE = 6'h0D;

  function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                         input logic [31:0] wdata,
                                         input logic [31:0] wmask,
                                         input logic [31:0] field_mask);
    logic [31:0] m;
    m = wmask & field_mask;
    return (old_val & ~m) | (wdata & m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_regfile_if
// Description : Pipeline-to-CSR access, exception commit and interrupt bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_regfile_if;
  import csr_regfile_pkg::*;

  logic                   csr_we;
  logic [C_CSR_NUM_W-1:0] csr_num;
  logic [31:0]            csr_wmask;
  logic [31:0]            csr_wdata;
  logic [31:0]            csr_rdata;
  logic                   excp_flush;
  logic                   ertn_flush;
  logic [5:0]             ecode;
  logic [2:0]             esubcode;
  logic [31:0]            epc;
  logic [7:0]             hw_int_in;
  logic [31:0]            era;
  logic [31:0]            eentry;
  logic                   has_int;

  modport master (
    output csr_we, csr_num, csr_wmask, csr_wdata,
    output excp_flush, ertn_flush, ecode, esubcode, epc, hw_int_in,
    input  csr_rdata, era, eentry, has_int
  );

  modport slave (
    input  csr_we, csr_num, csr_wmask, csr_wdata,
    input  excp_flush, ertn_flush, ecode, esubcode, epc, hw_int_in,
    output csr_rdata, era, eentry, has_int
  );

endinterface
`default_nettype wire

// File: rtl/csr_timer.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer
// Description : TCFG/TVAL countdown timer with one-shot or periodic expiry
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer
  import csr_regfile_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic        tcfg_we,
  input  wire logic [31:0] wmask,
  input  wire logic [31:0] wdata,
  output logic      [31:0] tcfg,
  output logic      [31:0] tval,
  output logic             timer_set
);

  logic [31:0] r_tcfg;
  logic [31:0] r_tval;
  logic [31:0] w_tcfg_next;
  logic        w_expire;

  assign w_tcfg_next = wmerge(r_tcfg, wdata, wmask, 32'hFFFF_FFFF);
  assign w_expire    = ~tcfg_we & r_tcfg[C_TCFG_EN] & (r_tval == 32'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tcfg <= '0;
      r_tval <= '0;
    end else if (tcfg_we) begin
      r_tcfg <= w_tcfg_next;
      r_tval <= {w_tcfg_next[31:2], 2'b00};
    end else if (r_tcfg[C_TCFG_EN] && (r_tval != 32'd0)) begin
      // Expiry either reloads (periodic) or parks at zero until rewritten
      if (r_tval == 32'd1)
        r_tval <= r_tcfg[C_TCFG_PERIODIC] ? {r_tcfg[31:2], 2'b00} : 32'd0;
      else
        r_tval <= r_tval - 32'd1;
    end
  end

  assign tcfg      = r_tcfg;
  assign tval      = r_tval;
  assign timer_set = w_expire;

endmodule
`default_nettype wire

// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
// Module      : csr_regfile
// Description : Exception/interrupt/timer CSR file with combinational read
// Revision    : 1.0 - initial release
// ============================================================================
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [31:0] CPU_ID = 32'h0
) (
  input  wire logic     clk,
  input  wire logic     resetn,
  csr_regfile_if.slave  bus
);

  logic [31:0] r_crmd;
  logic [31:0] r_prmd;
  logic [31:0] r_ecfg;
  logic [1:0]  r_is_sw;
  logic [7:0]  r_is_hw;
  logic        r_is_timer;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esubcode;
  logic [31:0] r_era;
  logic [31:0] r_eentry;
  logic [31:0] r_save [4];
  logic [31:0] r_tid;

  logic        w_we;
  logic        w_tcfg_we;
  logic        w_ticlr;
  logic        w_timer_set;
  logic [31:0] w_tcfg;
  logic [31:0] w_tval;
  logic [12:0] w_is;
  logic [31:0] w_estat;
  logic [31:0] w_rdata;

  // Any flush commit suppresses a software write in the same cycle
  assign w_we      = bus.csr_we & ~bus.excp_flush & ~bus.ertn_flush;
  assign w_tcfg_we = w_we & (bus.csr_num == C_CSR_TCFG);
  assign w_ticlr   = w_we & (bus.csr_num == C_CSR_TICLR)
                   & bus.csr_wdata[C_TICLR_CLR] & bus.csr_wmask[C_TICLR_CLR];

  csr_timer u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .tcfg_we   (w_tcfg_we),
    .wmask     (bus.csr_wmask),
    .wdata     (bus.csr_wdata),
    .tcfg      (w_tcfg),
    .tval      (w_tval),
    .timer_set (w_timer_set)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crmd <= C_CRMD_RESET;
      r_prmd <= '0;
    end else if (bus.excp_flush) begin
      r_prmd <= {r_prmd[31:3], r_crmd[2:0]};
      r_crmd <= {r_crmd[31:3], 3'b000};
    end else if (bus.ertn_flush) begin
      r_crmd <= {r_crmd[31:3], r_prmd[2:0]};
    end else if (w_we) begin
      if (bus.csr_num == C_CSR_CRMD)
        r_crmd <= wmerge(r_crmd, bus.csr_wdata, bus.csr_wmask, C_CRMD_WMASK);
      if (bus.csr_num == C_CSR_PRMD)
        r_prmd <= wmerge(r_prmd, bus.csr_wdata, bus.csr_wmask, C_PRMD_WMASK);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ecode    <= '0;
      r_esubcode <= '0;
      r_era      <= '0;
    end else if (bus.excp_flush) begin
      r_ecode    <= bus.ecode;
      r_esubcode <= {6'b0, bus.esubcode};
      r_era      <= bus.epc;
    end else if (w_we && (bus.csr_num == C_CSR_ERA)) begin
      r_era <= wmerge(r_era, bus.csr_wdata, bus.csr_wmask, 32'hFFFF_FFFF);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ecfg   <= '0;
      r_eentry <= '0;
      r_tid    <= CPU_ID;
      r_is_sw  <= '0;
      for (int i = 0; i < 4; i++) r_save[i] <= '0;
    end else if (w_we) begin
      if (bus.csr_num == C_CSR_ECFG)
        r_ecfg <= wmerge(r_ecfg, bus.csr_wdata, bus.csr_wmask, C_ECFG_WMASK);
      if (bus.csr_num == C_CSR_EENTRY)
        r_eentry <= wmerge(r_eentry, bus.csr_wdata, bus.csr_wmask, C_EENTRY_WMASK);
      if (bus.csr_num == C_CSR_TID)
        r_tid <= wmerge(r_tid, bus.csr_wdata, bus.csr_wmask, 32'hFFFF_FFFF);
      if (bus.csr_num == C_CSR_ESTAT)
        r_is_sw <= (r_is_sw & ~bus.csr_wmask[1:0]) | (bus.csr_wdata[1:0] & bus.csr_wmask[1:0]);
      for (int i = 0; i < 4; i++)
        if (bus.csr_num == C_CSR_SAVE0 + 14'(i))
          r_save[i] <= wmerge(r_save[i], bus.csr_wdata, bus.csr_wmask, 32'hFFFF_FFFF);
    end
  end

  // Timer expiry outranks a same-cycle TICLR
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_hw    <= '0;
      r_is_timer <= 1'b0;
    end else begin
      r_is_hw <= bus.hw_int_in;
      if (w_timer_set)
        r_is_timer <= 1'b1;
      else if (w_ticlr)
        r_is_timer <= 1'b0;
    end
  end

  assign w_is    = {1'b0, r_is_timer, 1'b0, r_is_hw, r_is_sw};
  assign w_estat = {1'b0, r_esubcode, r_ecode, 3'b000, w_is};

  always_comb begin
    w_rdata = '0;
    case (bus.csr_num)
      C_CSR_CRMD:   w_rdata = r_crmd;
      C_CSR_PRMD:   w_rdata = r_prmd;
      C_CSR_ECFG:   w_rdata = r_ecfg;
      C_CSR_ESTAT:  w_rdata = w_estat;
      C_CSR_ERA:    w_rdata = r_era;
      C_CSR_EENTRY: w_rdata = r_eentry;
      C_CSR_SAVE0:  w_rdata = r_save[0];
      C_CSR_SAVE1:  w_rdata = r_save[1];
      C_CSR_SAVE2:  w_rdata = r_save[2];
      C_CSR_SAVE3:  w_rdata = r_save[3];
      C_CSR_TID:    w_rdata = r_tid;
      C_CSR_TCFG:   w_rdata = w_tcfg;
      C_CSR_TVAL:   w_rdata = w_tval;
      default:      w_rdata = '0;
    endcase
  end

  assign bus.csr_rdata = w_rdata;
  assign bus.era       = r_era;
  assign bus.eentry    = r_eentry;
  assign bus.has_int   = r_crmd[C_CRMD_IE] & (|(w_is & r_ecfg[12:0]));

endmodule
`default_nettype wire

// File: tb/tb_csr_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_regfile
// Description : Directed scoreboard bench for csr_regfile
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_regfile;

  localparam logic [13:0] N_CRMD = 14'h00, N_PRMD = 14'h01, N_ECFG = 14'h04,
                          N_ESTAT = 14'h05, N_ERA = 14'h06, N_EENTRY = 14'h0C,
                          N_SAVE0 = 14'h30, N_SAVE1 = 14'h31, N_SAVE2 = 14'h32,
                          N_TID = 14'h40, N_TCFG = 14'h41, N_TVAL = 14'h42,
                          N_TICLR = 14'h44, N_UNIMP = 14'h02;
  localparam int S_RDATA = 0, S_ERA = 1, S_EENTRY = 2, S_HASINT = 3;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic rd_req;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  csr_regfile_if ifc ();

  csr_regfile #(.CPU_ID(32'h0000_00A5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  // Monitor: pops the expected response whenever a read is presented
  always @(negedge clk) begin
    if (rd_req) begin
      exp_t e;
      logic [31:0] act;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: read presented with no expected entry");
      end else begin
        e = sb.pop_front();
        case (e.sel)
          S_ERA:    act = ifc.era;
          S_EENTRY: act = ifc.eentry;
          S_HASINT: act = {31'b0, ifc.has_int};
          default:  act = ifc.csr_rdata;
        endcase
        if ((act & e.mask) !== e.exp) begin
          failures++;
          $display("FAIL %s: got 0x%08h want 0x%08h (mask 0x%08h)",
                   e.name, act & e.mask, e.exp, e.mask);
        end
      end
    end
  end

  task automatic chk(input logic [13:0] num, input int sel, input logic [31:0] mask,
                     input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name; e.sel = sel; e.mask = mask; e.exp = exp & mask;
    ifc.csr_num = num;
    sb.push_back(e);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] data);
    ifc.csr_we = 1'b1; ifc.csr_num = num; ifc.csr_wmask = mask; ifc.csr_wdata = data;
    @(posedge clk); #1;
    ifc.csr_we = 1'b0;
  endtask

  task automatic flush(input logic ex, input logic er, input logic [5:0] ec,
                       input logic [2:0] esc, input logic [31:0] pc, input logic [13:0] wnum);
    ifc.excp_flush = ex; ifc.ertn_flush = er; ifc.ecode = ec; ifc.esubcode = esc; ifc.epc = pc;
    ifc.csr_we = 1'b1; ifc.csr_num = wnum; ifc.csr_wmask = ALL; ifc.csr_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ifc.excp_flush = 1'b0; ifc.ertn_flush = 1'b0; ifc.csr_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; rd_req = 1'b0;
    ifc.csr_we = 1'b0; ifc.csr_num = '0; ifc.csr_wmask = '0; ifc.csr_wdata = '0;
    ifc.excp_flush = 1'b0; ifc.ertn_flush = 1'b0; ifc.ecode = '0; ifc.esubcode = '0;
    ifc.epc = '0; ifc.hw_int_in = '0;
    repeat (2) @(posedge clk); #1;

    chk(N_CRMD,   S_RDATA,  ALL, 32'h8,  "rst_crmd");
    chk(N_EENTRY, S_RDATA,  ALL, 32'h0,  "rst_eentry_rd");
    chk(N_EENTRY, S_EENTRY, ALL, 32'h0,  "rst_eentry_out");
    chk(N_CRMD,   S_ERA,    ALL, 32'h0,  "rst_era_out");
    chk(N_CRMD,   S_HASINT, ALL, 32'h0,  "rst_has_int");
    chk(N_TID,    S_RDATA,  ALL, 32'hA5, "rst_tid");
    chk(N_TVAL,   S_RDATA,  ALL, 32'h0,  "rst_tval");
    resetn = 1'b1;

    wr(N_EENTRY, ALL, ALL);
    chk(N_EENTRY, S_RDATA,  ALL, 32'hFFFF_FFC0, "eentry_rd");
    chk(N_EENTRY, S_EENTRY, ALL, 32'hFFFF_FFC0, "eentry_out");
    wr(N_UNIMP, ALL, ALL);
    chk(N_UNIMP, S_RDATA, ALL, 32'h0, "unimp_rd");
    wr(N_TICLR, ALL, ALL);
    chk(N_TICLR, S_RDATA, ALL, 32'h0, "ticlr_rd");
    wr(N_TVAL, ALL, 32'h55);
    chk(N_TVAL, S_RDATA, ALL, 32'h0, "tval_ro");
    wr(N_ECFG, ALL, ALL);
    chk(N_ECFG, S_RDATA, ALL, 32'h1BFF, "ecfg_fields");
    wr(N_CRMD, 32'h7, 32'h7);
    chk(N_CRMD, S_RDATA, ALL, 32'hF, "crmd_wr");
    wr(N_PRMD, 32'h5, ALL);
    chk(N_PRMD, S_RDATA, ALL, 32'h5, "prmd_mask_set");
    wr(N_PRMD, 32'h1, 32'h0);
    chk(N_PRMD, S_RDATA, ALL, 32'h4, "prmd_mask_clr");

    flush(1'b1, 1'b0, 6'hB, 3'd1, 32'h1C00_0100, N_SAVE0);
    chk(N_PRMD,  S_RDATA, ALL, 32'h7, "excp_prmd");
    chk(N_CRMD,  S_RDATA, ALL, 32'h8, "excp_crmd");
    chk(N_ESTAT, S_RDATA, 32'h7FFF_0000, 32'h004B_0000, "excp_estat_code");
    chk(N_CRMD,  S_ERA,   ALL, 32'h1C00_0100, "excp_era_out");
    chk(N_ERA,   S_RDATA, ALL, 32'h1C00_0100, "excp_era_rd");
    chk(N_SAVE0, S_RDATA, ALL, 32'h0, "excp_drops_we");
    flush(1'b0, 1'b1, 6'h0, 3'd0, 32'h0, N_SAVE1);
    chk(N_CRMD,  S_RDATA, ALL, 32'hF, "ertn_crmd");
    chk(N_SAVE1, S_RDATA, ALL, 32'h0, "ertn_drops_we");
    flush(1'b1, 1'b1, 6'h8, 3'd0, 32'h1C00_0200, N_SAVE0);
    chk(N_CRMD,  S_RDATA, ALL, 32'h8, "prio_crmd");
    chk(N_PRMD,  S_RDATA, ALL, 32'h7, "prio_prmd");
    chk(N_CRMD,  S_ERA,   ALL, 32'h1C00_0200, "prio_era");
    chk(N_ESTAT, S_RDATA, 32'h7FFF_0000, 32'h0008_0000, "prio_estat_code");
    flush(1'b0, 1'b1, 6'h0, 3'd0, 32'h0, N_SAVE1);
    chk(N_CRMD,  S_RDATA, ALL, 32'hF, "ertn2_crmd");

    wr(N_SAVE2, ALL, 32'hA5A5_0F0F);
    chk(N_SAVE2, S_RDATA, ALL, 32'hA5A5_0F0F, "save2_rd");
    wr(N_TID, 32'hFFFF_0000, 32'hCAFE_0001);
    chk(N_TID, S_RDATA, ALL, 32'hCAFE_00A5, "tid_partial");

    wr(N_ESTAT, ALL, ALL);
    chk(N_ESTAT, S_RDATA, 32'h0000_FFFF, 32'h3, "estat_sw_is");
    chk(N_ESTAT, S_RDATA, 32'h7FFF_0000, 32'h0008_0000, "estat_code_ro");
    chk(N_CRMD,  S_HASINT, ALL, 32'h1, "sw_has_int");
    wr(N_ESTAT, 32'h3, 32'h0);
    chk(N_CRMD,  S_HASINT, ALL, 32'h0, "sw_clr_has_int");

    wr(N_ECFG, ALL, 32'h4);
    ifc.hw_int_in = 8'h01;
    chk(N_CRMD,  S_HASINT, ALL, 32'h0, "hw_int_latency");
    chk(N_ESTAT, S_RDATA, 32'h1FFF, 32'h4, "hw_is2");
    chk(N_CRMD,  S_HASINT, ALL, 32'h1, "hw_has_int");
    ifc.hw_int_in = 8'h00;
    chk(N_CRMD,  S_HASINT, ALL, 32'h1, "hw_drop_latency");
    chk(N_CRMD,  S_HASINT, ALL, 32'h0, "hw_drop_has_int");

    wr(N_ECFG, ALL, 32'h800);
    wr(N_TCFG, ALL, 32'hB);
    for (int v = 8; v >= 1; v--) chk(N_TVAL, S_RDATA, ALL, 32'(v), $sformatf("tval_per_%0d", v));
    chk(N_TVAL,  S_RDATA, ALL, 32'h8, "tval_reload");
    chk(N_ESTAT, S_RDATA, 32'h800, 32'h800, "timer_is11");
    chk(N_CRMD,  S_HASINT, ALL, 32'h1, "timer_has_int");
    wr(N_TICLR, 32'h1, 32'h1);
    chk(N_ESTAT, S_RDATA, 32'h800, 32'h0, "ticlr_clears");
    chk(N_TCFG,  S_RDATA, ALL, 32'hB, "tcfg_rd");
    chk(N_TVAL,  S_RDATA, ALL, 32'h2, "tval_before_race");
    wr(N_TICLR, 32'h1, 32'h1);
    chk(N_ESTAT, S_RDATA, 32'h800, 32'h800, "set_beats_clr");
    wr(N_TICLR, 32'h1, 32'h1);

    wr(N_TCFG, ALL, 32'h5);
    for (int v = 4; v >= 1; v--) chk(N_TVAL, S_RDATA, ALL, 32'(v), $sformatf("tval_one_%0d", v));
    chk(N_TVAL,  S_RDATA, ALL, 32'h0, "tval_oneshot_zero");
    chk(N_TVAL,  S_RDATA, ALL, 32'h0, "tval_oneshot_hold");
    chk(N_ESTAT, S_RDATA, 32'h800, 32'h800, "oneshot_is11");
    wr(N_TICLR, 32'h1, 32'h1);
    chk(N_ESTAT, S_RDATA, 32'h800, 32'h0, "oneshot_clr");

    wr(N_TCFG, ALL, 32'h10);
    chk(N_TVAL, S_RDATA, ALL, 32'h10, "tval_en0_a");
    chk(N_TVAL, S_RDATA, ALL, 32'h10, "tval_en0_b");

    wr(N_TCFG, ALL, 32'h101);
    chk(N_TVAL, S_RDATA, ALL, 32'h100, "tval_run_a");
    chk(N_TVAL, S_RDATA, ALL, 32'hFF,  "tval_run_b");
    resetn = 1'b0;
    chk(N_TVAL,  S_RDATA, ALL, 32'h0,  "mid_rst_tval");
    chk(N_TCFG,  S_RDATA, ALL, 32'h0,  "mid_rst_tcfg");
    chk(N_SAVE2, S_RDATA, ALL, 32'h0,  "mid_rst_save2");
    chk(N_TID,   S_RDATA, ALL, 32'hA5, "mid_rst_tid");
    resetn = 1'b1;
    chk(N_TVAL,  S_RDATA, ALL, 32'h0,  "post_rst_stopped");

    ifc.excp_flush = 1'b1; ifc.epc = 32'h1C00_0300; ifc.ecode = 6'hC;
    resetn = 1'b0;
    chk(N_CRMD,  S_ERA,   ALL, 32'h0, "rst_flush_era");
    chk(N_ESTAT, S_RDATA, ALL, 32'h0, "rst_flush_estat");
    ifc.excp_flush = 1'b0;
    resetn = 1'b1;
    chk(N_CRMD,  S_RDATA, ALL, 32'h8, "rst_flush_crmd");

    @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
